// File: rtl/iq_pair_reader.sv
// iq_pair_reader: pops 16-bit I then Q words from a first-word-fall-through FIFO and
// packs them into {I, Q} frames held in a single-entry valid/ready output register.
// Also provides sync-driven pair re-alignment, a wrapping frame counter and a
// saturating mid-pair underrun counter.
module iq_pair_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_i,
    input  logic                    sync_i,
    input  logic [DATA_WIDTH-1:0]   fifo_data_i,
    input  logic                    fifo_empty_i,
    output logic                    fifo_rd_en_o,
    output logic [2*DATA_WIDTH-1:0] frame_data_o,
    output logic                    frame_valid_o,
    input  logic                    frame_ready_i,
    output logic [CNT_WIDTH-1:0]    frame_cnt_o,
    output logic [CNT_WIDTH-1:0]    underrun_cnt_o,
    output logic                    busy_o
);

    typedef enum logic {
        StGetI = 1'b0,
        StGetQ = 1'b1
    } state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [DATA_WIDTH-1:0]     r_i_word;
    logic [2*DATA_WIDTH-1:0]   r_frame_data;
    logic                      r_frame_valid;
    logic [CNT_WIDTH-1:0]      r_frame_cnt;
    logic [CNT_WIDTH-1:0]      r_underrun_cnt;
    logic                      w_slot_free;
    logic                      w_pop_i;
    logic                      w_pop_q;
    logic                      w_underrun;

    // Pop decode and next-state selection; sync_i overrides any pop or transition.
    always_comb begin
        w_state_next = r_state;
        w_slot_free  = !r_frame_valid || frame_ready_i;
        w_pop_i      = 1'b0;
        w_pop_q      = 1'b0;
        w_underrun   = 1'b0;
        unique case (r_state)
            StGetI: begin
                w_pop_i = enable_i && !fifo_empty_i && !sync_i;
                if (w_pop_i) begin
                    w_state_next = StGetQ;
                end
            end
            StGetQ: begin
                // enable_i is deliberately ignored here so a started pair always completes.
                w_pop_q    = !fifo_empty_i && !sync_i && w_slot_free;
                w_underrun = fifo_empty_i && !sync_i;
                if (w_pop_q) begin
                    w_state_next = StGetI;
                end
            end
            default: w_state_next = StGetI;
        endcase
        if (sync_i) begin
            w_state_next = StGetI;
        end
    end

    // State register and half-pair I word; sync drops the held I word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StGetI;
            r_i_word <= '0;
        end else begin
            r_state <= w_state_next;
            if (sync_i) begin
                r_i_word <= '0;
            end else if (w_pop_i) begin
                r_i_word <= fifo_data_i;
            end
        end
    end

    // Output slot: a load wins over a drain in the same cycle, so valid stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
        end else if (w_pop_q) begin
            r_frame_data  <= {r_i_word, fifo_data_i};
            r_frame_valid <= 1'b1;
        end else if (r_frame_valid && frame_ready_i) begin
            r_frame_valid <= 1'b0;
        end
    end

    // Diagnostic counters: frames wrap, underrun cycles saturate at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt    <= '0;
            r_underrun_cnt <= '0;
        end else begin
            if (w_pop_q) begin
                r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            end
            if (w_underrun && (r_underrun_cnt != {CNT_WIDTH{1'b1}})) begin
                r_underrun_cnt <= r_underrun_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign fifo_rd_en_o   = w_pop_i || w_pop_q;
    assign frame_data_o   = r_frame_data;
    assign frame_valid_o  = r_frame_valid;
    assign frame_cnt_o    = r_frame_cnt;
    assign underrun_cnt_o = r_underrun_cnt;
    assign busy_o         = (r_state == StGetQ);

endmodule

// File: tb/tb_iq_pair_reader.sv
// Bench for iq_pair_reader: queue-based FIFO, a behavioural pair-building model checked
// every cycle, and directed scenarios with hand-computed literal expectations.
module tb_iq_pair_reader;

    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = 4;
    localparam int          MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable_i;
    logic            sync_i;
    logic [DW-1:0]   fifo_data_i;
    logic            fifo_empty_i;
    logic            fifo_rd_en_o;
    logic [2*DW-1:0] frame_data_o;
    logic            frame_valid_o;
    logic            frame_ready_i;
    logic [CW-1:0]   frame_cnt_o;
    logic [CW-1:0]   underrun_cnt_o;
    logic            busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    iq_pair_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_i       (enable_i),
        .sync_i         (sync_i),
        .fifo_data_i    (fifo_data_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .frame_data_o   (frame_data_o),
        .frame_valid_o  (frame_valid_o),
        .frame_ready_i  (frame_ready_i),
        .frame_cnt_o    (frame_cnt_o),
        .underrun_cnt_o (underrun_cnt_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- FIFO environment ----------------
    logic [DW-1:0] fifo_q[$];
    logic          rd_seen  = 1'b0;
    logic          rst_seen = 1'b0;

    initial begin
        fifo_empty_i = 1'b1;
        fifo_data_i  = '0;
    end

    // Applies the pop decided at the previous rising edge, then presents the new head.
    always @(negedge clk) begin
        #1;
        if (rst_seen) fifo_q.delete();
        else if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // ---------------- Behavioural model ----------------
    bit              m_half;       // an I word is held waiting for its Q
    logic [DW-1:0]   m_i;
    bit              m_slot_valid;
    logic [2*DW-1:0] m_slot_data;
    int              m_frames;
    int              m_under;

    function automatic bit exp_rd();
        if (sync_i || fifo_empty_i) return 1'b0;
        if (!m_half) return enable_i;
        return !m_slot_valid || frame_ready_i;
    endfunction

    always @(posedge clk) begin
        bit rd;
        bit drained;
        if (reset) begin
            m_half = 0; m_i = '0; m_slot_valid = 0; m_slot_data = '0;
            m_frames = 0; m_under = 0;
        end else begin
            rd      = exp_rd();
            drained = m_slot_valid && frame_ready_i;
            if (m_half && fifo_empty_i && !sync_i && m_under < MAX) m_under++;
            if (drained) m_slot_valid = 0;
            if (rd && m_half) begin
                m_slot_data  = {m_i, fifo_data_i};
                m_slot_valid = 1;
                m_frames     = (m_frames + 1) % (MAX + 1);
                m_half       = 0;
            end else if (rd) begin
                m_i    = fifo_data_i;
                m_half = 1;
            end
            if (sync_i) m_half = 0;
        end
    end

    // Per-cycle comparison, well clear of the rising edge.
    always @(negedge clk) begin
        #3;
        rd_seen  = fifo_rd_en_o;
        rst_seen = reset;
        check("rd_en", 32'(fifo_rd_en_o), 32'(exp_rd()));
        check("frame_valid", 32'(frame_valid_o), 32'(m_slot_valid));
        if (m_slot_valid) check("frame_data", frame_data_o, m_slot_data);
        check("frame_cnt", 32'(frame_cnt_o), 32'(m_frames));
        check("underrun_cnt", 32'(underrun_cnt_o), 32'(m_under));
        check("busy", 32'(busy_o), 32'(m_half));
    end

    // ---------------- Directed stimulus ----------------
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic peek();
        #4;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable_i = 1'b0; sync_i = 1'b0; frame_ready_i = 1'b1;
        nxt(); nxt();
        reset = 1'b0;
        peek();
        check("rst_valid", 32'(frame_valid_o), 32'd0);
        check("rst_data", frame_data_o, 32'h0);
        check("rst_cnt", 32'(frame_cnt_o), 32'd0);
        check("rst_under", 32'(underrun_cnt_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);

        // Back-to-back pairs.
        nxt();
        fifo_q.push_back(16'h1111); fifo_q.push_back(16'h2222);
        fifo_q.push_back(16'h3333); fifo_q.push_back(16'h4444);
        enable_i = 1'b1;
        peek(); check("b2b_pop0", 32'(fifo_rd_en_o), 32'd1);
        nxt(); peek(); check("b2b_pop1", 32'(fifo_rd_en_o), 32'd1);
        nxt(); peek(); check("b2b_frame0", frame_data_o, 32'h11112222);
        check("b2b_pop2", 32'(fifo_rd_en_o), 32'd1);
        nxt(); peek(); check("b2b_pop3", 32'(fifo_rd_en_o), 32'd1);
        nxt(); peek(); check("b2b_frame1", frame_data_o, 32'h33334444);
        check("b2b_cnt", 32'(frame_cnt_o), 32'd2);
        check("b2b_under", 32'(underrun_cnt_o), 32'd0);
        check("b2b_idle", 32'(fifo_rd_en_o), 32'd0);

        // Underrun: I word alone, Q arrives four cycles later.
        nxt(); fifo_q.push_back(16'hAAAA);
        for (int i = 0; i < 3; i++) begin
            nxt(); peek(); check("udr_busy", 32'(busy_o), 32'd1);
        end
        nxt(); fifo_q.push_back(16'hBBBB);
        nxt(); enable_i = 1'b0;
        peek(); check("udr_frame", frame_data_o, 32'hAAAABBBB);
        check("udr_cnt", 32'(underrun_cnt_o), 32'd3);

        // Backpressure: six words, slot blocked.
        nxt(); frame_ready_i = 1'b0; enable_i = 1'b1;
        for (int w = 1; w <= 6; w++) fifo_q.push_back(DW'(w * 16'h0101));
        nxt(); nxt(); nxt();
        for (int i = 0; i < 3; i++) begin
            nxt(); peek();
            check("bp_stall", 32'(fifo_rd_en_o), 32'd0);
            check("bp_hold", frame_data_o, 32'h01010202);
        end
        nxt(); frame_ready_i = 1'b1;
        peek(); check("bp_qpop", 32'(fifo_rd_en_o), 32'd1);
        nxt(); frame_ready_i = 1'b0;
        peek(); check("bp_frame1", frame_data_o, 32'h03030404);
        check("bp_valid", 32'(frame_valid_o), 32'd1);
        nxt(); nxt(); frame_ready_i = 1'b1;
        nxt(); enable_i = 1'b0;
        peek(); check("bp_frame2", frame_data_o, 32'h05050606);
        check("bp_cnt", 32'(frame_cnt_o), 32'd6);

        // Sync realignment.
        nxt(); enable_i = 1'b1; fifo_q.push_back(16'h0001);
        nxt(); fifo_q.push_back(16'h0002); fifo_q.push_back(16'h0003); sync_i = 1'b1;
        peek(); check("sync_nopop", 32'(fifo_rd_en_o), 32'd0);
        nxt(); sync_i = 1'b0;
        peek(); check("sync_cnt", 32'(frame_cnt_o), 32'd6);
        nxt(); nxt(); enable_i = 1'b0;
        peek(); check("sync_frame", frame_data_o, 32'h00020003);
        check("sync_cnt2", 32'(frame_cnt_o), 32'd7);

        // Enable dropped mid-pair.
        nxt(); enable_i = 1'b1;
        fifo_q.push_back(16'h0A0A); fifo_q.push_back(16'h0B0B); fifo_q.push_back(16'h0C0C);
        nxt(); enable_i = 1'b0;
        peek(); check("en_qpop", 32'(fifo_rd_en_o), 32'd1);
        nxt(); peek(); check("en_frame", frame_data_o, 32'h0A0A0B0B);
        check("en_hold0", 32'(fifo_rd_en_o), 32'd0);
        nxt(); peek(); check("en_hold1", 32'(fifo_rd_en_o), 32'd0);

        // Starvation to saturation, then reset.
        nxt(); enable_i = 1'b1;
        nxt(); enable_i = 1'b0;
        repeat (20) nxt();
        peek(); check("sat_under", 32'(underrun_cnt_o), 32'(MAX));
        check("sat_cnt", 32'(frame_cnt_o), 32'd8);
        nxt(); reset = 1'b1;
        nxt(); reset = 1'b0;
        peek();
        check("rst2_valid", 32'(frame_valid_o), 32'd0);
        check("rst2_data", frame_data_o, 32'h0);
        check("rst2_cnt", 32'(frame_cnt_o), 32'd0);
        check("rst2_under", 32'(underrun_cnt_o), 32'd0);
        check("rst2_busy", 32'(busy_o), 32'd0);
        check("rst2_rd", 32'(fifo_rd_en_o), 32'd0);
        nxt(); nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iq_pair_reader.md
# iq_pair_reader

Drains a synchronous first-word-fall-through sample FIFO, one 16-bit word at a time, and rebuilds 32-bit I/Q frames, I word first, then Q word. Frames go to a single-entry output register with a valid/ready handshake toward the downstream transmit path. Sits on the read side of the RX/TX sample FIFO. Also provides pair re-alignment, a frame counter and an underrun counter for diagnostics.

## Interface
- DATA_WIDTH, 16, width of one FIFO word (one I or Q sample)
- CNT_WIDTH, 16, width of frame and underrun counters

- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- enable_i  in  1  permits starting a new pair (I pop)
- sync_i  in  1  single-cycle pulse; discard any half-built pair
- fifo_data_i  in  DATA_WIDTH  FIFO head word, valid whenever fifo_empty_i=0
- fifo_empty_i  in  1  FIFO empty flag
- fifo_rd_en_o  out  1  pop head this cycle (combinational)
- frame_data_o  out  2*DATA_WIDTH  {I, Q}, I in upper half
- frame_valid_o  out  1  frame_data_o holds an unconsumed frame
- frame_ready_i  in  1  downstream accepts frame when valid&ready
- frame_cnt_o  out  CNT_WIDTH  frames emitted, wrapping
- underrun_cnt_o  out  CNT_WIDTH  mid-pair starvation cycles, saturating
- busy_o  out  1  state is GET_Q (half pair held)

## Operation
- FIFO contract: head word on fifo_data_i when fifo_empty_i=0. fifo_rd_en_o=1 consumes it. The next head word and updated empty flag appear the following cycle. fifo_rd_en_o is never asserted while fifo_empty_i=1.
- States: GET_I, GET_Q. Reset state is GET_I.
- GET_I: pop when enable_i=1, fifo_empty_i=0, sync_i=0. On pop, latch i_reg<=fifo_data_i and go to GET_Q. Otherwise stay.
- GET_Q: pop when fifo_empty_i=0, sync_i=0, and the output slot is free (frame_valid_o=0 or frame_ready_i=1). On pop:
  - frame_data_o<={i_reg, fifo_data_i}
  - frame_valid_o<=1
  - frame_cnt_o+1 (wraps)
  - go to GET_I
- enable_i is ignored in GET_Q: a started pair always completes.
- Output handshake: valid&ready with no new frame loaded clears frame_valid_o. Load and drain in the same cycle keeps valid=1 with the new data. frame_data_o is stable while valid&!ready.
- sync_i=1: no pop that cycle; state<=GET_I; i_reg is discarded. The output register and counters are unaffected. This takes priority over everything except reset.
- underrun_cnt_o increments on every cycle with state=GET_Q, fifo_empty_i=1 and sync_i=0. It saturates at all-ones. Backpressure stalls are not counted.
- Reset values:
  - state GET_I
  - fifo_rd_en_o 0
  - frame_data_o 0
  - frame_valid_o 0
  - frame_cnt_o 0
  - underrun_cnt_o 0
  - busy_o 0
  - i_reg 0
- Reset mid-pair discards the half pair. The FIFO is reset by the same reset, so no stale word is paired.

## Timing
- fifo_rd_en_o is combinational from state, enable_i, sync_i, fifo_empty_i, frame_valid_o and frame_ready_i.
- Latency: Q pop in cycle N gives frame_valid_o=1 in cycle N+1.
- Peak throughput: one frame per 2 cycles. Pops are back-to-back (I in N, Q in N+1, I in N+2 ...) when the FIFO is non-empty and ready=1.
- With ready=0 and a frame held, I may still be popped. Q is held off until the slot frees, so at most one complete frame plus one I word are buffered.
- Counters are registered and update the cycle after the qualifying event.

## Test plan
- Back-to-back: FIFO holds 0x1111,0x2222,0x3333,0x4444; enable=1, ready=1 -> fifo_rd_en_o high 4 consecutive cycles; frames 0x11112222 then 0x33334444 on cycles 2 and 4 after the first pop; frame_cnt_o=2; underrun_cnt_o=0.
- Underrun: FIFO holds only 0xAAAA; 3 cycles later write 0xBBBB -> busy_o=1 throughout the gap; underrun_cnt_o counts the empty cycles seen in GET_Q (≥3 after write latency); then one frame 0xAAAABBBB.
- Backpressure: ready=0 with 6 words queued -> exactly 3 pops (I,Q,I), then fifo_rd_en_o=0 and frame_data_o stable; ready=1 for one cycle -> next Q popped in the same cycle, valid stays 1, and the second frame appears.
- Sync realignment: pop I=0x0001, pulse sync_i while the FIFO holds 0x0002,0x0003 -> no pop during the sync cycle; the next frame is 0x00020003; frame_cnt_o is unchanged by the sync.
- Enable: enable_i=0 mid-pair with the FIFO non-empty -> Q still popped and the frame emitted, then no further pops until enable_i=1.
- Reset/saturation: force underrun_cnt_o to all-ones via a long starvation (CNT_WIDTH=4, 20 cycles) -> holds at 0xF; assert reset -> all outputs return to their reset values the next cycle.
